// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator stage.
package product_accumulator_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int N_TERMS_DEF = 4;
    localparam int ACC_W_DEF   = 10;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit + 8-bit adder clamped to all-ones on overflow.
// Latency: combinational.
// Backpressure: none, pure datapath.
module sat_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [7:0]   b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {{(W-7){1'b0}}, b};
    assign ovf  = full[W];
    assign sum  = ovf ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of up to N_TERMS multiplier products into a saturating accumulator.
// Latency: result valid the cycle after the group-closing product is accepted.
// Backpressure: in_ready drops while a result waits for out_ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;

    sat_adder #(.W(ACC_W)) u_sat_adder (
        .a   (acc),
        .b   (in_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        // clear overrides both a pending product and a pending result
        if (clear) begin
            state_nxt = ST_ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
        end else if (state == ST_ACC) begin
            if (in_valid) begin
                acc_nxt = add_sum;
                cnt_nxt = cnt_inc;
                sat_nxt = sat | add_ovf;
                if (in_last || cnt_inc == LAST_CNT) begin
                    state_nxt = ST_HOLD;
                end
            end
        end else begin
            if (out_ready) begin
                state_nxt = ST_ACC;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
            end
        end
    end

    // Handshake outputs depend only on registered state
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized bench for product_accumulator (two parameter sets).
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid, in_last, out_ready, sel_b;
    logic [7:0] in_prod;

    logic       a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_out_sat;
    logic       b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_out_sat;
    logic [9:0] a_out_sum, b_out_sum;
    logic [3:0] a_out_count, b_out_count;

    logic       obs_in_ready, obs_out_valid, obs_out_sat;
    logic [9:0] obs_out_sum;
    logic [3:0] obs_out_count;

    int n_checks = 0;
    int n_fail   = 0;
    int m_sum, m_cnt;
    bit m_done;

    always #5 clk = ~clk;

    assign a_in_valid  = in_valid & ~sel_b;
    assign b_in_valid  = in_valid & sel_b;
    assign a_out_ready = out_ready & ~sel_b;
    assign b_out_ready = out_ready & sel_b;

    assign obs_in_ready  = sel_b ? b_in_ready  : a_in_ready;
    assign obs_out_valid = sel_b ? b_out_valid : a_out_valid;
    assign obs_out_sum   = sel_b ? b_out_sum   : a_out_sum;
    assign obs_out_count = sel_b ? b_out_count : a_out_count;
    assign obs_out_sat   = sel_b ? b_out_sat   : a_out_sat;

    product_accumulator #(.N_TERMS(4), .ACC_W(10)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_count (a_out_count),
        .out_sat   (a_out_sat)
    );

    product_accumulator #(.N_TERMS(8), .ACC_W(10)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_count (b_out_count),
        .out_sat   (b_out_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nterms();
        return sel_b ? 8 : 4;
    endfunction

    function automatic int exp_sum();
        return (m_sum > 1023) ? 1023 : m_sum;
    endfunction

    function automatic bit exp_sat();
        return m_sum > 1023;
    endfunction

    task automatic model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  obs_in_ready,  1);
        check({tag, "_out_valid"}, obs_out_valid, 0);
        check({tag, "_out_sum"},   obs_out_sum,   0);
        check({tag, "_out_count"}, obs_out_count, 0);
        check({tag, "_out_sat"},   obs_out_sat,   0);
    endtask

    // Offer one product; the model accepts it only if the DUT was ready at the edge
    task automatic send(input int p, input bit last);
        int  w;
        bit  rdy;
        w = 0;
        while (!obs_in_ready && w < 20) begin
            tick();
            w++;
        end
        check("send_ready_wait", obs_in_ready, 1);
        rdy      = obs_in_ready;
        in_valid = 1'b1;
        in_prod  = p[7:0];
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rdy) begin
            m_sum += p;
            m_cnt++;
            m_done = (m_cnt == nterms()) || last;
        end
        check("latency_out_valid", obs_out_valid, m_done);
        check("latency_in_ready",  obs_in_ready,  !m_done);
    endtask

    // Wait `stall` cycles with out_ready low, then take the result
    task automatic collect(input int stall, input bit hold_v);
        check("res_sum",   obs_out_sum,   exp_sum());
        check("res_count", obs_out_count, m_cnt);
        check("res_sat",   obs_out_sat,   exp_sat());
        for (int i = 0; i < stall; i++) begin
            in_valid = hold_v;
            in_prod  = 8'd9;
            tick();
            check("stall_out_valid", obs_out_valid, 1);
            check("stall_in_ready",  obs_in_ready,  0);
            check("stall_sum",       obs_out_sum,   exp_sum());
            check("stall_count",     obs_out_count, m_cnt);
            check("stall_sat",       obs_out_sat,   exp_sat());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_reset();
        check("post_hs_out_valid", obs_out_valid, 0);
        check("post_hs_in_ready",  obs_in_ready,  1);
        check("post_hs_count",     obs_out_count, 0);
        check("post_hs_sum",       obs_out_sum,   0);
    endtask

    initial begin
        int p;
        bit last;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_prod   = 8'd0;
        sel_b     = 1'b0;
        model_reset();
        tick();
        check_reset("in_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset("after_reset");

        // Basic group of four
        send(9, 0); send(50, 0); send(60, 0); send(108, 0);
        check("basic_sum", obs_out_sum, 227);
        collect(0, 0);

        // Early close with in_last, then the next group starts from zero
        send(225, 0); send(225, 1);
        check("last_sum",   obs_out_sum,   450);
        check("last_count", obs_out_count, 2);
        collect(0, 0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        check("next_sum", obs_out_sum, 10);
        collect(0, 0);

        // Saturation on the 8-term instance
        sel_b = 1'b1;
        for (int i = 0; i < 8; i++) send(225, 0);
        check("sat_sum",   obs_out_sum,   1023);
        check("sat_flag",  obs_out_sat,   1);
        check("sat_count", obs_out_count, 8);
        collect(0, 0);
        sel_b = 1'b0;

        // Output stall with upstream holding 9
        send(20, 0); send(30, 0); send(40, 0); send(50, 0);
        collect(5, 1);
        send(9, 0); send(1, 0); send(1, 0); send(1, 0);
        check("stall_next_sum", obs_out_sum, 12);
        collect(0, 0);

        // clear mid-group drops the product offered alongside it
        send(9, 0); send(50, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_prod  = 8'd77;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check("clear_count", obs_out_count, 0);
        check("clear_sum",   obs_out_sum,   0);
        send(60, 0); send(108, 0); send(12, 0); send(5, 0);
        check("clear_grp_sum",   obs_out_sum,   185);
        check("clear_grp_count", obs_out_count, 4);
        collect(0, 0);

        // clear during hold discards the pending result
        send(1, 0); send(2, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check("clear_hold_valid", obs_out_valid, 0);
        check("clear_hold_ready", obs_in_ready,  1);
        check("clear_hold_sum",   obs_out_sum,   0);

        // Asynchronous reset mid-group and during hold
        send(3, 0); send(4, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        send(9, 0); send(50, 0); send(60, 0); send(108, 0);
        check("rst_mid_sum", obs_out_sum, 227);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_hold");
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        send(5, 0); send(6, 1);
        check("rst_hold_sum", obs_out_sum, 11);
        collect(0, 0);

        // Randomized groups across both instances
        for (int g = 0; g < 30; g++) begin
            sel_b = (g % 3 == 0);
            while (!m_done) begin
                p    = $urandom_range(0, 255);
                last = ($urandom_range(0, 5) == 0);
                send(p, last);
            end
            collect($urandom_range(0, 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
